// File: rtl/qam_pkg.sv
// Shared constants and helpers for the QAM symbol mapper: default geometry,
// Gray decode and odd-integer level mapping.
package qam_pkg;

  localparam int DEF_BITS_PER_SYM = 4;
  localparam int DEF_OSR          = 8;
  localparam int DEF_AMP_W        = 8;

  // Axis codes never exceed 4 bits (BITS_PER_SYM <= 8), so 8 bits is ample.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Level for index k on an M-ary axis: 2k - (M-1).
  function automatic logic signed [15:0] level(input logic [7:0] code, input int m);
    return signed'(16'(2 * int'(code) - (m - 1)));
  endfunction

endpackage

// File: rtl/qam_axis_map.sv
// Combinational code-to-amplitude map for one QAM axis.
// Gray-coded axes are selected by defining QAM_MAPPER_GRAY_EN.
module qam_axis_map
  import qam_pkg::*;
#(
  parameter int CODE_W = 2,
  parameter int AMP_W  = 8
) (
  input  logic        [CODE_W-1:0] code,
  output logic signed [AMP_W-1:0]  amp
);

  localparam int M = 1 << CODE_W;

  logic        [7:0]  k;
  logic signed [15:0] lvl;

`ifdef QAM_MAPPER_GRAY_EN
  assign k = gray2bin(8'(code));
`else
  assign k = 8'(code);
`endif

  assign lvl = level(k, M);
  assign amp = lvl[AMP_W-1:0];

endmodule

// File: rtl/qam_symbol_mapper.sv
// Serial-bit to QAM I/Q level mapper: bit collector, free-running symbol phase
// counter and registered I/Q outputs held for OSR clocks. Gray option: QAM_MAPPER_GRAY_EN.
module qam_symbol_mapper
  import qam_pkg::*;
#(
  parameter int BITS_PER_SYM = DEF_BITS_PER_SYM,
  parameter int OSR          = DEF_OSR,
  parameter int AMP_W        = DEF_AMP_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic signed [AMP_W-1:0] sym_i,
  output logic signed [AMP_W-1:0] sym_q,
  output logic                    sym_strobe,
  output logic                    underrun
);

  localparam int HALF  = BITS_PER_SYM / 2;
  localparam int CNT_W = $clog2(BITS_PER_SYM + 1);
  localparam int PH_W  = $clog2(OSR);

  logic        [BITS_PER_SYM-1:0] shreg;
  logic        [CNT_W-1:0]        bit_cnt;
  logic        [PH_W-1:0]         phase_cnt;
  logic                           tick;
  logic                           full;
  logic                           accept;
  logic signed [AMP_W-1:0]        amp_i;
  logic signed [AMP_W-1:0]        amp_q;

  assign tick      = (phase_cnt == PH_W'(OSR - 1));
  assign full      = (bit_cnt == CNT_W'(BITS_PER_SYM));
  assign bit_ready = (bit_cnt < CNT_W'(BITS_PER_SYM));
  assign accept    = bit_valid && bit_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (tick) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // First accepted bit ends up at the MSB, i.e. the I-axis MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (accept) begin
        shreg <= {shreg[BITS_PER_SYM-2:0], bit_in};
      end
      // A full collector cannot accept, so drain and accept never coincide.
      if (tick && full) begin
        bit_cnt <= '0;
      end else if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  qam_axis_map #(.CODE_W(HALF), .AMP_W(AMP_W)) u_map_i (
    .code (shreg[BITS_PER_SYM-1 -: HALF]),
    .amp  (amp_i)
  );

  qam_axis_map #(.CODE_W(HALF), .AMP_W(AMP_W)) u_map_q (
    .code (shreg[HALF-1:0]),
    .amp  (amp_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_i      <= '0;
      sym_q      <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_strobe <= tick;
      if (tick) begin
        if (full) begin
          sym_i    <= amp_i;
          sym_q    <= amp_q;
          underrun <= 1'b0;
        end else begin
          sym_i    <= '0;
          sym_q    <= '0;
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed self-checking bench for qam_symbol_mapper (BITS_PER_SYM=4, OSR=8, AMP_W=8).
module tb_qam_symbol_mapper;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic signed [7:0] sym_i;
  logic signed [7:0] sym_q;
  logic              sym_strobe;
  logic              underrun;

  int checks = 0;
  int errors = 0;

  qam_symbol_mapper #(.BITS_PER_SYM(4), .OSR(8), .AMP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .sym_strobe (sym_strobe),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Hand-written level tables for a 4-level axis.
  function automatic int lvl(input logic [1:0] c);
`ifdef QAM_MAPPER_GRAY_EN
    case (c)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
`else
    case (c)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b10:   return 1;
      default: return 3;
    endcase
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic check_sym(input string tag, input int ei, input int eq, input logic eu);
    chk({tag, "_strobe"}, sym_strobe, 1);
    chk({tag, "_i"}, sym_i, ei);
    chk({tag, "_q"}, sym_q, eq);
    chk({tag, "_underrun"}, underrun, eu);
  endtask

  initial begin
    logic [3:0] cur;
    int         ncur;
    logic [3:0] expq[$];
    logic [3:0] e;
    int         acc_total;
    int         acc_win;
    int         strobes;
    logic       acc_now;
    logic       b;

    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    step();
    step();
    step();
    chk("rst_sym_i", sym_i, 0);
    chk("rst_sym_q", sym_q, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    chk("rel_ready", bit_ready, 1);

    // First symbol: bits 0,0,1,0 during the first period.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("full_ready_low", bit_ready, 0);
    step();
    step();
    step();
    chk("first_strobe_not_early", sym_strobe, 0);
    step();
    check_sym("sym1", -3, lvl(2'b10), 1'b0);
    chk("sym1_ready_back", bit_ready, 1);
    for (int c = 0; c < 7; c++) begin
      step();
      chk("hold_strobe", sym_strobe, 0);
      chk("hold_i", sym_i, -3);
      chk("hold_q", sym_q, lvl(2'b10));
    end

    // Empty period -> underrun.
    step();
    check_sym("underrun", 0, 0, 1'b1);

    // Full symbol clears underrun: bits 1,1,0,1.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int c = 0; c < 4; c++) step();
    check_sym("sym3", lvl(2'b11), lvl(2'b01), 1'b0);

    // Back-pressure: valid held high for 10 symbol periods.
    cur       = '0;
    ncur      = 0;
    acc_total = 0;
    acc_win   = 0;
    strobes   = 0;
    bit_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      b       = 1'($urandom_range(0, 1));
      bit_in  = b;
      acc_now = bit_ready;
      step();
      if (acc_now) begin
        acc_total++;
        acc_win++;
        cur = {cur[2:0], b};
        ncur++;
        if (ncur == 4) begin
          expq.push_back(cur);
          ncur = 0;
        end
      end
      if (sym_strobe) begin
        strobes++;
        chk("bp_window_accepts", acc_win, 4);
        chk("bp_ready_at_phase0", bit_ready, 1);
        acc_win = 0;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("bp_sym_i", sym_i, lvl(e[3:2]));
          chk("bp_sym_q", sym_q, lvl(e[1:0]));
          chk("bp_underrun", underrun, 0);
        end else begin
          chk("bp_symbol_available", 0, 1);
        end
      end
    end
    bit_valid = 1'b0;
    chk("bp_total_accepts", acc_total, 40);
    chk("bp_strobes", strobes, 10);

    // Fourth bit lands in the tick cycle: bits 1,0,0 then 1 at phase 7.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int c = 0; c < 4; c++) step();
    send_bit(1'b1);
    check_sym("tickedge_underrun", 0, 0, 1'b1);
    chk("tickedge_ready_low", bit_ready, 0);
    for (int c = 0; c < 8; c++) step();
    check_sym("tickedge_sym", lvl(2'b10), lvl(2'b01), 1'b0);

    // Reset with two bits collected.
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sym_i", sym_i, 0);
    chk("midrst_sym_q", sym_q, 0);
    chk("midrst_strobe", sym_strobe, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_ready", bit_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("midrst_ready_after2", bit_ready, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("midrst_ready_after4", bit_ready, 0);
    step();
    step();
    step();
    chk("midrst_strobe_not_early", sym_strobe, 0);
    step();
    check_sym("midrst_sym", lvl(2'b01), lvl(2'b11), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
